// File: rtl/z_buffer_stage_if.sv
// z_buffer_stage_if: pixel handshake, clear control and frame-buffer write bundle.
// accept_cnt/reject_cnt exist only when ZBUF_STATS_EN is defined.
interface z_buffer_stage_if #(
    parameter int X_WIDTH     = 4,
    parameter int Y_WIDTH     = 4,
    parameter int Z_WIDTH     = 8,
    parameter int PIXEL_WIDTH = 16
`ifdef ZBUF_STATS_EN
    ,
    parameter int CNT_WIDTH   = 16
`endif
);
    logic [PIXEL_WIDTH-1:0]       pix_in;
    logic                         send_z_buffer;
    logic                         rdy_z_buffer;
    logic                         clear;
    logic                         clear_done;
    logic                         fb_valid;
    logic [X_WIDTH+Y_WIDTH-1:0]   fb_addr;
    logic [Z_WIDTH-1:0]           fb_z;
`ifdef ZBUF_STATS_EN
    logic [CNT_WIDTH-1:0]         accept_cnt;
    logic [CNT_WIDTH-1:0]         reject_cnt;
`endif

    modport master (
        output pix_in, send_z_buffer, clear,
        input  rdy_z_buffer, clear_done, fb_valid, fb_addr, fb_z
`ifdef ZBUF_STATS_EN
        , input accept_cnt, reject_cnt
`endif
    );

    modport slave (
        input  pix_in, send_z_buffer, clear,
        output rdy_z_buffer, clear_done, fb_valid, fb_addr, fb_z
`ifdef ZBUF_STATS_EN
        , output accept_cnt, reject_cnt
`endif
    );
endinterface

// File: rtl/z_buffer_stage.sv
// z_buffer_stage: depth test against a cleared-to-far depth memory, emitting frame-buffer writes.
// Define ZBUF_STATS_EN to add saturating accept/reject counters.
module z_buffer_stage #(
    parameter int X_WIDTH     = 4,
    parameter int Y_WIDTH     = 4,
    parameter int Z_WIDTH     = 8,
    parameter int PIXEL_WIDTH = 16
`ifdef ZBUF_STATS_EN
    ,
    parameter int CNT_WIDTH   = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    z_buffer_stage_if.slave   zif
);
    localparam int A_WIDTH = X_WIDTH + Y_WIDTH;
    localparam int DEPTH   = 1 << A_WIDTH;

    typedef enum logic [1:0] {CLEAR, IDLE, READ, CMP} state_t;

    state_t               state_q;
    logic [A_WIDTH-1:0]   sweep_q;
    logic [A_WIDTH-1:0]   addr_q;
    logic [A_WIDTH-1:0]   fb_addr_q;
    logic [Z_WIDTH-1:0]   z_q;
    logic [Z_WIDTH-1:0]   rd_q;
    logic [Z_WIDTH-1:0]   fb_z_q;
    logic                 fb_valid_q;
    logic                 clear_done_q;
    logic [Z_WIDTH-1:0]   mem [DEPTH];
    logic                 pass;
    logic                 we;
    logic [A_WIDTH-1:0]   waddr;
    logic [Z_WIDTH-1:0]   wdata;

    assign pass  = state_q == CMP && z_q < rd_q;
    assign we    = state_q == CLEAR || pass;
    assign waddr = state_q == CLEAR ? sweep_q : addr_q;
    assign wdata = state_q == CLEAR ? '1 : z_q;

    // The read port always follows addr_q, so rd_q is valid in CMP.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_q <= mem[addr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            sweep_q      <= '0;
            addr_q       <= '0;
            z_q          <= '0;
            fb_valid_q   <= 1'b0;
            fb_addr_q    <= '0;
            fb_z_q       <= '0;
            clear_done_q <= 1'b0;
        end else begin
            fb_valid_q   <= pass;
            clear_done_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (&sweep_q) begin
                        state_q      <= IDLE;
                        clear_done_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (zif.clear) begin
                        state_q <= CLEAR;
                        sweep_q <= '0;
                    end else if (zif.send_z_buffer) begin
                        addr_q  <= zif.pix_in[PIXEL_WIDTH-1:Z_WIDTH];
                        z_q     <= zif.pix_in[Z_WIDTH-1:0];
                        state_q <= READ;
                    end
                end
                READ: state_q <= CMP;
                default: begin
                    if (pass) begin
                        fb_addr_q <= addr_q;
                        fb_z_q    <= z_q;
                    end
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign zif.rdy_z_buffer = state_q == IDLE && !zif.clear;
    assign zif.clear_done   = clear_done_q;
    assign zif.fb_valid     = fb_valid_q;
    assign zif.fb_addr      = fb_addr_q;
    assign zif.fb_z         = fb_z_q;

`ifdef ZBUF_STATS_EN
    logic [CNT_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] rej_q;

    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && zif.clear)) begin
            acc_q <= '0;
            rej_q <= '0;
        end else if (state_q == CMP) begin
            if (pass && !(&acc_q)) acc_q <= acc_q + 1'b1;
            if (!pass && !(&rej_q)) rej_q <= rej_q + 1'b1;
        end
    end

    assign zif.accept_cnt = acc_q;
    assign zif.reject_cnt = rej_q;
`endif
endmodule

// File: doc/z_buffer_stage.md
Name: z_buffer_stage

Overview:
Depth-test stage directly downstream of the 4-input FIFO and contention-tree arbiter. It consumes one pixel per send/ready handshake and reads the stored depth at the pixel's (x,y) address. If the new pixel is strictly nearer, it updates the depth memory and emits a frame-buffer write. An internal sweep clears the depth memory to "far" after reset or on request.

Parameters:
X_WIDTH, 4, x-coordinate bits
Y_WIDTH, 4, y-coordinate bits
Z_WIDTH, 8, depth bits; all-ones = farthest
PIXEL_WIDTH, 16, pixel word width; must equal X_WIDTH+Y_WIDTH+Z_WIDTH
CNT_WIDTH, 16, statistics counter width (only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_in  in  PIXEL_WIDTH  pixel word from the arbiter: {x, y, z}, x in the MSBs, z in the LSBs
send_z_buffer  in  1  pixel on pix_in is valid
rdy_z_buffer  out  1  stage can accept a pixel this cycle
clear  in  1  request a depth-memory clear
clear_done  out  1  one-cycle pulse when a clear sweep finishes
fb_valid  out  1  one-cycle frame-buffer write strobe
fb_addr  out  X_WIDTH+Y_WIDTH  frame-buffer address {x,y}
fb_z  out  Z_WIDTH  depth written
accept_cnt  out  CNT_WIDTH  pixels that passed the depth test (optional feature only)
reject_cnt  out  CNT_WIDTH  pixels that failed the depth test (optional feature only)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Depth memory: 2^(X_WIDTH+Y_WIDTH) entries of Z_WIDTH bits. Synchronous write; registered read with 1-cycle latency.
- States: CLEAR, IDLE, READ, CMP.
- Reset:
  - state=CLEAR, sweep address=0.
  - rdy_z_buffer=0, fb_valid=0, fb_addr=0, fb_z=0, clear_done=0, counters=0.
  - Any pending pixel is discarded.
- CLEAR:
  - Writes all-ones to one entry per cycle, address 0 upward.
  - After writing the last entry (2^(X+Y)-1): go to IDLE and pulse clear_done for 1 cycle.
  - Full sweep takes 2^(X+Y) cycles (256 at defaults). clear is ignored while already clearing.
- IDLE:
  - rdy_z_buffer = (state==IDLE) && !clear. This is combinational from state and clear only; it does not depend on send_z_buffer.
  - If clear=1: go to CLEAR. Any simultaneous send is NOT accepted, because rdy is low that cycle.
  - Else if send_z_buffer=1: the transfer happens. Latch pix_in and go to READ.
  - Transfer rule: occurs only when send_z_buffer && rdy_z_buffer at a rising edge. The arbiter holds its data until the transfer.
- READ: present {x,y} to the memory read port; go to CMP.
- CMP:
  - Compare z_new against z_stored, unsigned.
  - If z_new < z_stored: write z_new at {x,y}, register fb_valid=1, fb_addr={x,y}, fb_z=z_new.
  - Else: no write, fb_valid stays 0.
  - Equal depth is rejected.
  - Go to IDLE.
- Timing:
  - Accept at edge E0 -> fb_valid high for exactly the cycle after edge E2.
  - rdy_z_buffer is high again in that same cycle.
  - Sustained throughput is 1 pixel per 3 cycles.
- Read-after-write to the same address on back-to-back pixels: the write at E2 completes before the next READ, so no forwarding is needed. The second pixel must see the updated depth.
- fb_addr and fb_z hold their last values when fb_valid=0.
- reset asserted in any state aborts the operation and restarts at CLEAR, as above.

Optional Feature:
Macro ZBUF_STATS_EN.
- Defined:
  - accept_cnt increments on each CMP pass; reject_cnt increments on each CMP fail.
  - Both saturate at all-ones.
  - Both are zeroed by reset and on entry to CLEAR from a clear request.
- Not defined: accept_cnt/reject_cnt ports and their logic are absent.

Test Plan:
1. Reset, hold send low -> rdy_z_buffer=0 for 256 cycles, then clear_done pulses once and rdy_z_buffer=1; every entry reads 0xFF.
2. After clear, send {x=3,y=5,z=0x40} -> fb_valid one cycle after the 2nd edge post-accept, fb_addr=0x35, fb_z=0x40; rdy low for 2 cycles.
3. Send {3,5,0x40} again, then {3,5,0x50}, back-to-back -> both rejected, fb_valid stays 0; then {3,5,0x10} -> accepted with fb_z=0x10. With ZBUF_STATS_EN: accept_cnt=2, reject_cnt=2.
4. In IDLE, assert clear and send_z_buffer together with pixel {1,1,0x00} -> pixel not accepted (rdy=0), 256-cycle sweep, clear_done; arbiter re-presents the pixel -> accepted, fb_z=0x00.
5. Accept a pixel, assert reset during READ -> no fb_valid, outputs zero, full clear sweep, clear_done.
6. Drive 20 random pixels with send held high continuously -> one transfer every 3 cycles; fb outputs match a reference depth model exactly.
